// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings and inter-stage control bundles for the E/M/W control pipe.
// Encodings mirror the shared decode header so both ends agree on field values.
package ctrl_pipe_pkg;

  localparam int TNEW_W = 2;

  localparam logic [1:0] A3_RD = 2'b00;
  localparam logic [1:0] A3_RT = 2'b01;
  localparam logic [1:0] A3_1F = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  typedef logic [TNEW_W-1:0] tnew_t;

  typedef struct packed {
    logic [2:0]  aluctr;
    logic        alube;
    logic [1:0]  rfwd;
    logic        regwr;
    logic        memwr;
    logic [4:0]  a3;
    tnew_t       tnew;
    logic [31:0] pc8;
  } e_t;

  typedef struct packed {
    logic [1:0]  rfwd;
    logic        regwr;
    logic        memwr;
    logic [4:0]  a3;
    tnew_t       tnew;
    logic [31:0] pc8;
  } m_t;

  typedef struct packed {
    logic [1:0]  rfwd;
    logic        regwr;
    logic [4:0]  a3;
    logic [31:0] pc8;
  } w_t;

  // Non-writers report $0 so forwarding can never match them.
  function automatic logic [4:0] a3_dec(
    input logic [1:0] sel,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic       regwr
  );
    logic [4:0] a3;
    a3 = rd;
    unique case (1'b1)
      (sel == A3_RT): a3 = rt;
      (sel == A3_1F): a3 = 5'd31;
      default:        a3 = rd;
    endcase
    return regwr ? a3 : 5'd0;
  endfunction

  function automatic tnew_t tnew_dec(
    input logic [1:0] rfwd,
    input logic       regwr,
    input tnew_t      t_alu,
    input tnew_t      t_load,
    input tnew_t      t_link
  );
    tnew_t t;
    t = t_alu;
    unique case (1'b1)
      (rfwd == WD_DM):  t = t_load;
      (rfwd == WD_PC4): t = t_link;
      default:          t = t_alu;
    endcase
    return regwr ? t : '0;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage_reg.sv
// Generic pipeline register slice with synchronous clear, bubble and enable.
// Bubble loads an all-zero bundle, which is a NOP in every stage.
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (bubble)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipe: latches decoded control into E/M/W and tracks A3/Tnew per stage.
// Stall only bubbles E; M and W always advance.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter logic [1:0] TNEW_ALU  = 2'd1,
  parameter logic [1:0] TNEW_LOAD = 2'd2,
  parameter logic [1:0] TNEW_LINK = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr_D,
  input  logic [31:0] pc_D,
  input  logic [1:0]  A3_sel,
  input  logic [2:0]  ALUctr_D,
  input  logic        ALUBE_sel_D,
  input  logic [1:0]  RFWDW_sel_D,
  input  logic        RegWr_D,
  input  logic        MemWr_D,
  output logic [2:0]  ALUctr_E,
  output logic        ALUBE_sel_E,
  output logic [4:0]  A3_E,
  output logic [4:0]  A3_M,
  output logic [4:0]  A3_W,
  output logic [1:0]  Tnew_E,
  output logic [1:0]  Tnew_M,
  output logic        MemWr_M,
  output logic [1:0]  RFWDW_sel_M,
  output logic [1:0]  RFWDW_sel_W,
  output logic        RegWr_W,
  output logic [31:0] pc8_E,
  output logic [31:0] pc8_M,
  output logic [31:0] pc8_W
);

  e_t d_b;
  e_t e_q;
  m_t m_d;
  m_t m_q;
  w_t w_d;
  w_t w_q;

  logic unused_instr;
  assign unused_instr = ^{instr_D[31:21], instr_D[10:0]};

  always_comb begin
    d_b        = '0;
    d_b.aluctr = ALUctr_D;
    d_b.alube  = ALUBE_sel_D;
    d_b.rfwd   = RFWDW_sel_D;
    d_b.regwr  = RegWr_D;
    d_b.memwr  = MemWr_D;
    d_b.a3     = a3_dec(A3_sel, instr_D[20:16],
                        instr_D[15:11], RegWr_D);
    d_b.tnew   = tnew_dec(RFWDW_sel_D, RegWr_D,
                          TNEW_ALU, TNEW_LOAD, TNEW_LINK);
    d_b.pc8    = pc_D + 32'd8;
  end

  always_comb begin
    m_d       = '0;
    m_d.rfwd  = e_q.rfwd;
    m_d.regwr = e_q.regwr;
    m_d.memwr = e_q.memwr;
    m_d.a3    = e_q.a3;
    m_d.tnew  = (e_q.tnew == '0) ? '0 : e_q.tnew - 2'd1;
    m_d.pc8   = e_q.pc8;
  end

  always_comb begin
    w_d       = '0;
    w_d.rfwd  = m_q.rfwd;
    w_d.regwr = m_q.regwr;
    w_d.a3    = m_q.a3;
    w_d.pc8   = m_q.pc8;
  end

  ctrl_stage_reg #(.W($bits(e_t))) u_e (
    .clk    (clk),
    .reset  (reset),
    .en     (1'b1),
    .bubble (stall),
    .d      (d_b),
    .q      (e_q)
  );

  ctrl_stage_reg #(.W($bits(m_t))) u_m (
    .clk    (clk),
    .reset  (reset),
    .en     (1'b1),
    .bubble (1'b0),
    .d      (m_d),
    .q      (m_q)
  );

  ctrl_stage_reg #(.W($bits(w_t))) u_w (
    .clk    (clk),
    .reset  (reset),
    .en     (1'b1),
    .bubble (1'b0),
    .d      (w_d),
    .q      (w_q)
  );

  assign ALUctr_E    = e_q.aluctr;
  assign ALUBE_sel_E = e_q.alube;
  assign A3_E        = e_q.a3;
  assign Tnew_E      = e_q.tnew;
  assign pc8_E       = e_q.pc8;
  assign A3_M        = m_q.a3;
  assign Tnew_M      = m_q.tnew;
  assign MemWr_M     = m_q.memwr;
  assign RFWDW_sel_M = m_q.rfwd;
  assign pc8_M       = m_q.pc8;
  assign A3_W        = w_q.a3;
  assign RFWDW_sel_W = w_q.rfwd;
  assign RegWr_W     = w_q.regwr;
  assign pc8_W       = w_q.pc8;

endmodule
